// File: rtl/pf_ccc_lock_supervisor.sv
// Lock supervisor for NUM_PLL CCC/PLL instances on a single reference clock.
// Filters synchronised lock flags, releases domain resets in staggered order,
// drops every domain back into reset on loss of lock, and soft-resets PLLs
// that do not lock within the timeout. Retry and loss counts saturate at 255.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | domains in reset, filtering lock, timing out toward a retry
// PLL_RST   | PLL_SOFTRESET pulse on the unlocked PLLs
// RELEASE   | domain resets deasserting one by one, STAGGER apart
// RUN       | all domains running, SYS_READY high
module pf_ccc_lock_supervisor #(
  parameter int NUM_PLL        = 2,
  parameter int LOCK_FILTER    = 256,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STAGGER        = 16,
  parameter int PLL_RST_CYCLES = 8
) (
  input  logic               REF_CLK,
  input  logic               RESET,
  input  logic [NUM_PLL-1:0] PLL_LOCK,
  input  logic               CLEAR_CNT,
  output logic [NUM_PLL-1:0] DOMAIN_RESET,
  output logic               SYS_READY,
  output logic [NUM_PLL-1:0] PLL_SOFTRESET,
  output logic [7:0]         RETRY_CNT,
  output logic [7:0]         LOSS_CNT,
  output logic [2:0]         STATE
);

  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT);
  localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int PW = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;

  localparam logic [FW-1:0] FILT_DONE = FW'(LOCK_FILTER);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STG_LOAD  = SW'(STAGGER - 1);
  localparam logic [PW-1:0] PRST_LOAD = PW'(PLL_RST_CYCLES - 1);

  localparam logic [NUM_PLL-1:0] ALL_ONES = '1;

  localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
  localparam logic [2:0] ST_PLL_RST   = 3'd1;
  localparam logic [2:0] ST_RELEASE   = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;

  logic [NUM_PLL-1:0] sync1_q, lks_q;
  logic               all_lk;

  logic [2:0]         state_q, state_d;
  logic [FW-1:0]      filt_q, filt_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [SW-1:0]      stg_q, stg_d;
  logic [PW-1:0]      prst_q, prst_d;
  logic [NUM_PLL-1:0] dom_q, dom_d;
  logic               rdy_q, rdy_d;
  logic [NUM_PLL-1:0] srst_q, srst_d;
  logic [7:0]         retry_q, retry_d;
  logic [7:0]         loss_q, loss_d;
  logic               retry_inc, loss_inc;

  assign all_lk = &lks_q;

  // Two-flop synchroniser on the asynchronous lock flags.
  always_ff @(posedge REF_CLK) begin
    if (RESET) begin
      sync1_q <= '0;
      lks_q   <= '0;
    end else begin
      sync1_q <= PLL_LOCK;
      lks_q   <= sync1_q;
    end
  end

  // Next-state logic for the sequencing FSM, its timers and the statistics.
  always_comb begin
    state_d   = state_q;
    filt_d    = filt_q;
    tmr_d     = tmr_q;
    stg_d     = stg_q;
    prst_d    = prst_q;
    dom_d     = dom_q;
    rdy_d     = rdy_q;
    srst_d    = srst_q;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;

    case (state_q)
      ST_WAIT_LOCK: begin
        dom_d  = ALL_ONES;
        rdy_d  = 1'b0;
        srst_d = '0;
        // Release is checked first so it wins a tie with the timeout.
        if (all_lk && (filt_q == FILT_DONE)) begin
          state_d = ST_RELEASE;
          dom_d   = ALL_ONES << 1;
          stg_d   = STG_LOAD;
          filt_d  = '0;
          tmr_d   = '0;
        end else if (tmr_q == TMO_LAST) begin
          state_d   = ST_PLL_RST;
          // A glitching lock leaves no PLL to blame, so pulse them all.
          srst_d    = all_lk ? ALL_ONES : ~lks_q;
          prst_d    = PRST_LOAD;
          retry_inc = 1'b1;
          filt_d    = '0;
          tmr_d     = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
          if (!all_lk) begin
            filt_d = '0;
          end else if (filt_q != FILT_DONE) begin
            filt_d = filt_q + 1'b1;
          end
        end
      end

      ST_PLL_RST: begin
        if (prst_q == '0) begin
          state_d = ST_WAIT_LOCK;
          srst_d  = '0;
          filt_d  = '0;
          tmr_d   = '0;
        end else begin
          prst_d = prst_q - 1'b1;
        end
      end

      ST_RELEASE: begin
        if (!all_lk) begin
          state_d  = ST_WAIT_LOCK;
          dom_d    = ALL_ONES;
          rdy_d    = 1'b0;
          loss_inc = 1'b1;
          filt_d   = '0;
          tmr_d    = '0;
        end else if (dom_q == '0) begin
          state_d = ST_RUN;
          rdy_d   = 1'b1;
        end else if (stg_q == '0) begin
          // Resets form a thermometer code; shifting frees the next domain.
          dom_d = dom_q << 1;
          stg_d = STG_LOAD;
        end else begin
          stg_d = stg_q - 1'b1;
        end
      end

      ST_RUN: begin
        if (!all_lk) begin
          state_d  = ST_WAIT_LOCK;
          dom_d    = ALL_ONES;
          rdy_d    = 1'b0;
          loss_inc = 1'b1;
          filt_d   = '0;
          tmr_d    = '0;
        end
      end

      default: begin
        state_d = ST_WAIT_LOCK;
        dom_d   = ALL_ONES;
        rdy_d   = 1'b0;
        srst_d  = '0;
        filt_d  = '0;
        tmr_d   = '0;
      end
    endcase

    retry_d = retry_q;
    loss_d  = loss_q;
    if (CLEAR_CNT) begin
      retry_d = '0;
      loss_d  = '0;
    end else begin
      if (retry_inc && (retry_q != 8'hFF)) retry_d = retry_q + 1'b1;
      if (loss_inc && (loss_q != 8'hFF))   loss_d  = loss_q + 1'b1;
    end
  end

  // State, timer and output registers.
  always_ff @(posedge REF_CLK) begin
    if (RESET) begin
      state_q <= ST_WAIT_LOCK;
      filt_q  <= '0;
      tmr_q   <= '0;
      stg_q   <= '0;
      prst_q  <= '0;
      dom_q   <= ALL_ONES;
      rdy_q   <= 1'b0;
      srst_q  <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      tmr_q   <= tmr_d;
      stg_q   <= stg_d;
      prst_q  <= prst_d;
      dom_q   <= dom_d;
      rdy_q   <= rdy_d;
      srst_q  <= srst_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  assign DOMAIN_RESET  = dom_q;
  assign SYS_READY     = rdy_q;
  assign PLL_SOFTRESET = srst_q;
  assign RETRY_CNT     = retry_q;
  assign LOSS_CNT      = loss_q;
  assign STATE         = state_q;

endmodule

// File: tb/tb_pf_ccc_lock_supervisor.sv
// Bench for pf_ccc_lock_supervisor: vector table for the basic release,
// hand sequences for timeout, glitch, loss, saturation and mid-release reset,
// then random lock activity against a phase/age reference model.
module tb_pf_ccc_lock_supervisor;
  localparam int NP  = 2;
  localparam int LF  = 4;
  localparam int LT  = 32;
  localparam int ST  = 3;
  localparam int PRC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic [NP-1:0] lock = '0;
  logic [NP-1:0] dom, sr;
  logic          rdy;
  logic [7:0]    retry, loss;
  logic [2:0]    state;

  always #5 clk = ~clk;

  pf_ccc_lock_supervisor #(
    .NUM_PLL(NP), .LOCK_FILTER(LF), .LOCK_TIMEOUT(LT),
    .STAGGER(ST), .PLL_RST_CYCLES(PRC)
  ) dut (
    .REF_CLK(clk), .RESET(rst), .PLL_LOCK(lock), .CLEAR_CNT(clr),
    .DOMAIN_RESET(dom), .SYS_READY(rdy), .PLL_SOFTRESET(sr),
    .RETRY_CNT(retry), .LOSS_CNT(loss), .STATE(state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase (0 wait,1 pll reset,2 release,3 run), cycles spent
  // in the phase, length of the current run of locked samples, and a two-deep
  // history of sampled lock flags.
  int            m_ph = 0, m_age = 0, m_run = 0, m_retry = 0, m_loss = 0;
  logic [NP-1:0] m_s1 = '0, m_lks = '0, m_mask = '0;

  function automatic void m_go(int ph);
    m_ph  = ph;
    m_age = 0;
    m_run = 0;
  endfunction

  function automatic void model_edge();
    bit all_lk;
    bit rinc;
    bit linc;
    rinc = 1'b0;
    linc = 1'b0;
    if (rst) begin
      m_go(0);
      m_retry = 0; m_loss = 0;
      m_s1 = '0; m_lks = '0; m_mask = '0;
      return;
    end
    all_lk = &m_lks;
    case (m_ph)
      0: begin
        if (all_lk && m_run >= LF) m_go(2);
        else if (m_age == LT - 1) begin
          m_mask = all_lk ? {NP{1'b1}} : ~m_lks;
          m_go(1);
          rinc = 1'b1;
        end else begin
          m_age++;
          m_run = all_lk ? ((m_run < LF) ? m_run + 1 : LF) : 0;
        end
      end
      1: if (m_age == PRC - 1) m_go(0); else m_age++;
      2: begin
        if (!all_lk) begin m_go(0); linc = 1'b1; end
        else if (m_age == (NP - 1) * ST) m_go(3);
        else m_age++;
      end
      default: if (!all_lk) begin m_go(0); linc = 1'b1; end
    endcase
    if (clr) begin
      m_retry = 0; m_loss = 0;
    end else begin
      if (rinc && m_retry < 255) m_retry++;
      if (linc && m_loss < 255) m_loss++;
    end
    m_lks = m_s1;
    m_s1  = lock;
  endfunction

  function automatic logic [NP-1:0] m_dom();
    logic [NP-1:0] d;
    d = '1;
    if (m_ph == 3) d = '0;
    else if (m_ph == 2)
      for (int k = 0; k < NP; k++) d[k] = (m_age < k * ST);
    return d;
  endfunction

  function automatic logic [NP-1:0] m_sr();
    return (m_ph == 1) ? m_mask : '0;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    for (int c = 0; c < 40 && state !== s; c++) step();
    chk(nm, {29'd0, state}, {29'd0, s});
  endtask

  // Lock raised for the first time at the next edge: release on the sixth
  // sampling edge, second domain three edges later, RUN one edge after that.
  task automatic relock_seq(input string nm);
    logic [2:0]    es;
    logic [NP-1:0] ed;
    logic          er;
    lock = 2'b11;
    for (int k = 0; k <= 10; k++) begin
      step();
      es = (k < 6) ? 3'd0 : (k < 10) ? 3'd2 : 3'd3;
      ed = (k < 6) ? 2'b11 : (k < 9) ? 2'b10 : 2'b00;
      er = (k == 10);
      chk(nm, {26'd0, es == state, state, dom, rdy}, {26'd0, 1'b1, es, ed, er});
    end
  endtask

  typedef struct {
    logic          rst;
    logic [NP-1:0] lock;
    logic [2:0]    st;
    logic [NP-1:0] dom;
    logic          rdy;
  } vec_t;

  function automatic vec_t mk(logic r, logic [NP-1:0] l, logic [2:0] s,
                              logic [NP-1:0] d, logic y);
    vec_t v;
    v.rst = r; v.lock = l; v.st = s; v.dom = d; v.rdy = y;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    bit   sr0_seen;

    // Release timing after reset, lock first sampled at row 3 (edge t).
    tbl.push_back(mk(1'b1, 2'b00, 3'd0, 2'b11, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 3'd0, 2'b11, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 3'd0, 2'b11, 1'b0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1'b0, 2'b11, 3'd0, 2'b11, 1'b0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 2'b11, 3'd2, 2'b10, 1'b0));
    tbl.push_back(mk(1'b0, 2'b11, 3'd2, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b11, 3'd3, 2'b00, 1'b1));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; lock = tbl[i].lock; clr = 1'b0;
      step();
      chk($sformatf("vec%0d", i), {26'd0, state, dom, rdy},
          {26'd0, tbl[i].st, tbl[i].dom, tbl[i].rdy});
      chk($sformatf("vec%0d_cnt", i), {14'd0, sr, retry, loss}, 32'd0);
    end

    // Loss of lock from RUN, then relock with the same release timing.
    lock = 2'b10;
    step(); chk("loss_u0", {26'd0, state, dom, rdy}, {26'd0, 3'd3, 2'b00, 1'b1});
    step(); chk("loss_u1", {26'd0, state, dom, rdy}, {26'd0, 3'd3, 2'b00, 1'b1});
    step(); chk("loss_u2", {18'd0, state, dom, rdy, loss}, {18'd0, 3'd0, 2'b11, 1'b0, 8'd1});
    relock_seq("relock");

    // Reset one cycle after the first domain is released.
    lock = 2'b00;
    step(); step(); step();
    chk("loss2", {21'd0, state, loss}, {21'd0, 3'd0, 8'd2});
    lock = 2'b11;
    wait_state(3'd2, "rel_wait");
    rst = 1'b1;
    step();
    chk("rst_in_release", {11'd0, state, dom, rdy, sr, retry, loss},
        {11'd0, 3'd0, 2'b11, 1'b0, 2'b00, 8'd0, 8'd0});
    rst = 1'b0;
    relock_seq("after_rst");

    // Timeout with PLL 1 unlocked, twice.
    rst = 1'b1; lock = 2'b01; step(); rst = 1'b0;
    sr0_seen = 1'b0;
    for (int c = 1; c <= 31; c++) begin step(); sr0_seen |= sr[0]; end
    chk("tmo1_pre", {29'd0, state}, 32'd0);
    step(); sr0_seen |= sr[0];
    chk("tmo1_enter", {19'd0, state, sr, retry}, {19'd0, 3'd1, 2'b10, 8'd1});
    step(); sr0_seen |= sr[0];
    chk("tmo1_hold", {27'd0, state, sr}, {27'd0, 3'd1, 2'b10});
    step(); sr0_seen |= sr[0];
    chk("tmo1_exit", {27'd0, state, sr}, {27'd0, 3'd0, 2'b00});
    for (int c = 1; c <= 31; c++) begin step(); sr0_seen |= sr[0]; end
    chk("tmo2_pre", {29'd0, state}, 32'd0);
    step(); sr0_seen |= sr[0];
    chk("tmo2_enter", {19'd0, state, sr, retry}, {19'd0, 3'd1, 2'b10, 8'd2});
    step(); step(); sr0_seen |= sr[0];
    chk("tmo2_exit", {27'd0, state, sr}, {27'd0, 3'd0, 2'b00});
    chk("tmo_pll0_quiet", {31'd0, sr0_seen}, 32'd0);

    // One-cycle drop of bit 1 after two good synced samples restarts the filter.
    rst = 1'b1; lock = 2'b00; step(); rst = 1'b0;
    lock = 2'b11; step(); step();
    lock = 2'b01; step();
    lock = 2'b11;
    for (int k = 3; k <= 8; k++) begin
      step();
      chk($sformatf("glitch_t%0d", k), {29'd0, state}, 32'd0);
    end
    step();
    chk("glitch_release", {21'd0, state, loss}, {21'd0, 3'd2, 8'd0});

    // LOSS_CNT saturation, then clear colliding with a loss.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      lock = 2'b11;
      wait_state(3'd2, "sat_wait");
      lock = 2'b00;
      step(); step(); step();
      if (i == 254) chk("sat_255", {24'd0, loss}, 32'd255);
    end
    chk("sat_hold", {24'd0, loss}, 32'd255);
    lock = 2'b11;
    wait_state(3'd2, "clr_wait");
    lock = 2'b00;
    step(); step();
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_vs_loss", {21'd0, state, loss}, {21'd0, 3'd0, 8'd0});

    // Random lock activity against the reference model.
    rst = 1'b1; step(); rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0)
        lock = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
      clr = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 999) == 0);
      step();
      chk("rnd", {8'd0, state, dom, rdy, sr, retry, loss},
          {8'd0, 3'(m_ph), m_dom(), m_ph == 3, m_sr(), 8'(m_retry), 8'(m_loss)});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pf_ccc_lock_supervisor.md
Name: pf_ccc_lock_supervisor

Overview:
Supervises lock for NUM_PLL PolarFire CCC/PLL instances. It runs from one free-running reference clock.
- Filters and synchronises the raw PLL_LOCK inputs.
- Releases per-domain resets in a fixed staggered order once every PLL is stably locked.
- Re-asserts all domain resets on any loss of lock.
- Pulses PLL soft reset for PLLs that fail to lock within a timeout.
- Sits between the CCC wrappers and the reset fan-out to the fabric clock domains, and exposes retry and loss statistics.

Parameters:
NUM_PLL, 2, number of supervised PLLs and domain resets (1..8)
LOCK_FILTER, 256, consecutive cycles all synced locks must be high before release (>=1)
LOCK_TIMEOUT, 65536, cycles in WAIT_LOCK before a PLL soft-reset retry (>LOCK_FILTER)
STAGGER, 16, cycles between successive domain reset releases (>=1)
PLL_RST_CYCLES, 8, PLL_SOFTRESET pulse width in cycles (>=1)

Ports:
REF_CLK  in  1  sole clock, free-running reference
RESET  in  1  synchronous, active-high reset
PLL_LOCK  in  NUM_PLL  raw PLL lock flags, asynchronous; bit i = PLL i
CLEAR_CNT  in  1  synchronous clear of RETRY_CNT and LOSS_CNT
DOMAIN_RESET  out  NUM_PLL  active-high reset per clock domain
SYS_READY  out  1  all domains out of reset and all PLLs locked
PLL_SOFTRESET  out  NUM_PLL  active-high soft-reset pulse per PLL
RETRY_CNT  out  8  saturating count of timeout retries
LOSS_CNT  out  8  saturating count of loss-of-lock events
STATE  out  3  encoded FSM state, for debug: WAIT_LOCK=0, PLL_RST=1, RELEASE=2, RUN=3

Behaviour:
- All outputs are registered.
- Reset values while RESET is high:
  - DOMAIN_RESET all 1s, SYS_READY 0, PLL_SOFTRESET 0.
  - Counters 0, STATE=WAIT_LOCK, synchroniser flops 0.
  - RESET takes priority over every other event. Asserting it mid-operation forces these values on the next edge.
- Lock synchroniser:
  - 2-flop synchroniser per bit gives lk_s, a 2-cycle latency.
  - all_lk = AND of lk_s.
- WAIT_LOCK:
  - Filter counter increments while all_lk=1 and clears whenever all_lk=0.
  - When the filter reaches LOCK_FILTER consecutive high samples, the next edge enters RELEASE.
  - Timeout counter starts at 0 on entry and increments every cycle. When it reaches LOCK_TIMEOUT-1 without release, the next edge enters PLL_RST.
  - If the filter and timeout complete in the same cycle, RELEASE wins.
- PLL_RST:
  - On entry, PLL_SOFTRESET[i]=1 for every i with lk_s[i]=0. If all lk_s are 1 (lock is glitching), all bits are pulsed.
  - The pulse is held for exactly PLL_RST_CYCLES cycles.
  - RETRY_CNT increments on entry and saturates at 255.
  - On exit, returns to WAIT_LOCK with both the timer and the filter cleared.
- RELEASE:
  - DOMAIN_RESET[0] deasserts on the entry edge. DOMAIN_RESET[k] deasserts k*STAGGER cycles after entry.
  - One cycle after DOMAIN_RESET[NUM_PLL-1] deasserts, the FSM enters RUN and SYS_READY=1 on that edge.
- RUN: outputs are held steady.
- Loss of lock (in RELEASE or RUN), when any lk_s=0:
  - Next edge: all DOMAIN_RESET=1, SYS_READY=0, LOSS_CNT increments (saturating at 255), STATE=WAIT_LOCK.
  - Worst-case latency from the raw PLL_LOCK falling edge is 3 cycles.
  - A lock drop in WAIT_LOCK only clears the filter and is not counted as a loss.
- Lock pulses shorter than 1 cycle may be missed; this is acceptable.
- CLEAR_CNT zeroes both counters on the next edge. A clear in the same cycle as an increment takes priority, giving 0.
- Counter widths are $clog2 of their terminal value. No wrap: the filter and timer stop at their terminal values.

Test Plan:
Common settings unless noted: NUM_PLL=2, LOCK_FILTER=4, LOCK_TIMEOUT=32, STAGGER=3, PLL_RST_CYCLES=2.
1. Release 2 cycles after reset, raise PLL_LOCK=2'b11 at edge t -> RELEASE entered at t+6; DOMAIN_RESET[0]=0 at t+6, DOMAIN_RESET[1]=0 at t+9; SYS_READY=1 at t+10.
2. Filter restart: PLL_LOCK=11 with a 1-cycle drop of bit 1 after 2 high synced samples -> filter restarts; release occurs 4 clean samples after the glitch; LOSS_CNT stays 0.
3. Timeout: PLL_LOCK=2'b01 held -> at 32 cycles in WAIT_LOCK, PLL_SOFTRESET=2'b10 for exactly 2 cycles; RETRY_CNT=1; a second timeout gives RETRY_CNT=2 with PLL 0 never pulsed.
4. Loss of lock: in RUN, drop PLL_LOCK[0] at edge u -> DOMAIN_RESET=11 and SYS_READY=0 by u+3; LOSS_CNT=1; relock replays scenario 1 timing.
5. Saturation and clear: force 256 losses -> LOSS_CNT=255. Then assert CLEAR_CNT in the same cycle as a loss -> LOSS_CNT=0.
6. Reset in RELEASE: assert RESET 1 cycle after DOMAIN_RESET[0] deasserts -> next edge: DOMAIN_RESET=11, STATE=0, counters 0; a normal sequence resumes after RESET drops.
